dkong_dl_router: RTL

Download router and core-reset sequencer between the HPS ioctl stream and the Donkey Kong core. It decodes ioctl writes into registered write strobes for the main-CPU, sound-CPU and wave ROM dual-port RAMs, and captures the game-variant byte and DIP-switch bytes. It holds the core in reset during any download and for a fixed settle period afterwards. It optionally accumulates a ROM checksum.

---
 rtl/dkong_dl_router.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/dkong_dl_router.sv
// Routes ioctl download bytes to the Donkey Kong ROM RAMs, variant and DIP registers, and sequences core reset.
// Optional ROM checksum output rom_sum is built only when DL_CHECKSUM_EN is defined.
module dkong_dl_router #(
  parameter int unsigned RST_HOLD = 16
) (
  input  logic        clk_sys,
  input  logic        I_RESETn,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic [7:0]  ioctl_index,
  output logic [15:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic        cpu_rom_we,
  output logic        snd_rom_we,
  output logic        wav_rom_we,
  output logic [4:0]  mod_onehot,
  output logic [7:0]  dip_sw,
  output logic        core_reset_n,
  output logic        dl_busy
`ifdef DL_CHECKSUM_EN
  ,
  output logic [15:0] rom_sum
`endif
);

  // state | meaning
  // IDLE  | after reset, waiting to pick LOAD or HOLD
  // LOAD  | download active, writes accepted
  // HOLD  | download finished, core held in reset for RST_HOLD cycles
  // RUN   | core running
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_RUN  = 2'd3;

  localparam logic [7:0] HOLD_LOAD = 8'(RST_HOLD - 1);

  logic [1:0] state, state_nxt;
  logic [7:0] hold_cnt;
  logic [7:0] variant;
  logic       wr_load, rom_ok, dip_ok, var_ok;
  logic       cpu_hit, snd_hit, wav_hit;
  logic       enter_load;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: state_nxt = ioctl_download ? ST_LOAD : ST_HOLD;
      ST_LOAD: if (!ioctl_download) state_nxt = ST_HOLD;
      ST_HOLD: begin
        if (ioctl_download)      state_nxt = ST_LOAD;
        else if (hold_cnt == '0) state_nxt = ST_RUN;
      end
      ST_RUN:  if (ioctl_download) state_nxt = ST_LOAD;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign enter_load = (state != ST_LOAD) && (state_nxt == ST_LOAD);

  assign wr_load = (state == ST_LOAD) && ioctl_wr;
  assign rom_ok  = wr_load && (ioctl_index == 8'd0) && (ioctl_addr[24:16] == '0);
  assign var_ok  = wr_load && (ioctl_index == 8'd1);
  assign dip_ok  = wr_load && (ioctl_index == 8'd254) && (ioctl_addr[24:3] == '0);

  assign cpu_hit = ~ioctl_addr[15];
  assign snd_hit = (ioctl_addr[15:12] == 4'hE);
  assign wav_hit = (ioctl_addr[15:12] == 4'hF);

  always_ff @(posedge clk_sys or negedge I_RESETn) begin
    if (!I_RESETn) begin
      state        <= ST_IDLE;
      hold_cnt     <= '0;
      core_reset_n <= 1'b0;
    end else begin
      state        <= state_nxt;
      core_reset_n <= (state_nxt == ST_RUN);
      if (state != ST_HOLD && state_nxt == ST_HOLD)
        hold_cnt <= HOLD_LOAD;
      else if (state == ST_HOLD && hold_cnt != '0)
        hold_cnt <= hold_cnt - 8'd1;
    end
  end

  always_ff @(posedge clk_sys or negedge I_RESETn) begin
    if (!I_RESETn) begin
      rom_addr   <= '0;
      rom_data   <= '0;
      cpu_rom_we <= 1'b0;
      snd_rom_we <= 1'b0;
      wav_rom_we <= 1'b0;
    end else begin
      cpu_rom_we <= rom_ok && cpu_hit;
      snd_rom_we <= rom_ok && snd_hit;
      wav_rom_we <= rom_ok && wav_hit;
      if (rom_ok) begin
        rom_addr <= ioctl_addr[15:0];
        rom_data <= ioctl_dout;
      end
    end
  end

  // Only DIP byte 0 drives the core, so the other seven bytes are not kept.
  always_ff @(posedge clk_sys or negedge I_RESETn) begin
    if (!I_RESETn) begin
      variant <= '0;
      dip_sw  <= '0;
    end else begin
      if (var_ok) variant <= ioctl_dout;
      if (dip_ok && ioctl_addr[2:0] == 3'd0) dip_sw <= ioctl_dout;
    end
  end

  always_comb begin
    mod_onehot = 5'b00000;
    case (variant)
      8'd0: mod_onehot = 5'b00001;
      8'd1: mod_onehot = 5'b00010;
      8'd2: mod_onehot = 5'b00100;
      8'd3: mod_onehot = 5'b01000;
      8'd4: mod_onehot = 5'b10000;
      default: mod_onehot = 5'b00000;
    endcase
  end

  assign dl_busy = (state != ST_RUN);

`ifdef DL_CHECKSUM_EN
  always_ff @(posedge clk_sys or negedge I_RESETn) begin
    if (!I_RESETn)
      rom_sum <= '0;
    else if (enter_load)
      rom_sum <= '0;
    else if (rom_ok)
      rom_sum <= rom_sum + {8'h00, ioctl_dout};
  end
`else
  logic unused_enter_load;
  assign unused_enter_load = enter_load;
`endif

endmodule
